bcd_operand_loader: RTL and testbench

//   Upstream operand-entry stage for the BCD adder datapath. Captures operand A,

---
 rtl/bcd_operand_loader.sv | 143 ++++++++++++++
 tb/tb_bcd_operand_loader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_operand_loader.sv
// bcd_operand_loader
//   Operand-entry stage for the BCD adder. A debounced pushbutton press captures,
//   in turn, operand A, then operand B together with the carry-in, from a 4-bit
//   switch digit. Non-BCD digits (> 9) are refused with a one-cycle reject pulse.
// Ports
//   clk, reset      : system clock (rising edge), async active-high reset
//   key_n           : raw active-low pushbutton, asynchronous to clk
//   din, cin_in     : digit and carry-in to capture
//   clear           : synchronous clear of operands/valid/state
//   a, b, cin       : captured operands and carry-in
//   valid           : a, b, cin form a complete set (level, held in S_READY)
//   state           : FSM state for LEDs (0 = S_A, 1 = S_B, 2 = S_READY)
//   reject          : one-cycle pulse, press ignored because din > 9
module bcd_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    input  logic [3:0] din,
    input  logic       cin_in,
    input  logic       clear,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic       cin,
    output logic       valid,
    output logic [1:0] state,
    output logic       reject
);

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_READY = 2'd2,
        S_ILL   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1, sync_key;
    logic             deb_level, deb_prev;
    logic [CNT_W-1:0] cnt;
    logic             press;

    state_t     st_q, st_d;
    logic [3:0] a_d, b_d;
    logic       cin_d, valid_d, reject_d;

    // Synchronizer and debouncer; released (1) is the idle level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= 1'b1;
            sync_key  <= 1'b1;
            deb_level <= 1'b1;
            deb_prev  <= 1'b1;
            cnt       <= '0;
        end else begin
            sync1    <= key_n;
            sync_key <= sync1;
            deb_prev <= deb_level;
            if (sync_key == deb_level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                deb_level <= sync_key;
                cnt       <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Registered edge detect: the event is the cycle after deb_level falls,
    // which gives the 2 + DEBOUNCE_CYCLES + 1 key-to-output latency.
    assign press = deb_prev & ~deb_level;

    always_comb begin
        st_d     = st_q;
        a_d      = a;
        b_d      = b;
        cin_d    = cin;
        valid_d  = valid;
        reject_d = 1'b0;
        if (clear) begin
            // Clear swallows any coincident press, with no reject.
            st_d    = S_A;
            a_d     = 4'd0;
            b_d     = 4'd0;
            cin_d   = 1'b0;
            valid_d = 1'b0;
        end else begin
            case (st_q)
                S_A: if (press) begin
                    if (din <= 4'd9) begin
                        a_d  = din;
                        st_d = S_B;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
                S_B: if (press) begin
                    if (din <= 4'd9) begin
                        b_d     = din;
                        cin_d   = cin_in;
                        valid_d = 1'b1;
                        st_d    = S_READY;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
                S_READY: if (press) begin
                    valid_d = 1'b0;
                    st_d    = S_A;
                end
                default: begin
                    valid_d = 1'b0;
                    st_d    = S_A;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q   <= S_A;
            a      <= 4'd0;
            b      <= 4'd0;
            cin    <= 1'b0;
            valid  <= 1'b0;
            reject <= 1'b0;
        end else begin
            st_q   <= st_d;
            a      <= a_d;
            b      <= b_d;
            cin    <= cin_d;
            valid  <= valid_d;
            reject <= reject_d;
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_bcd_operand_loader.sv
module tb_bcd_operand_loader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_n = 1'b1;
    logic [3:0] din = 4'd0;
    logic       cin_in = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] a, b;
    logic       cin, valid, reject;
    logic [1:0] state;

    bcd_operand_loader #(.DEBOUNCE_CYCLES(4), .CNT_W(19)) dut (
        .clk(clk), .reset(reset), .key_n(key_n), .din(din), .cin_in(cin_in),
        .clear(clear), .a(a), .b(b), .cin(cin), .valid(valid), .state(state),
        .reject(reject)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic       valid;
        logic [1:0] st;
        logic       rej;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic obs_t mk(int ea, int eb, int ec, int ev, int es, int er);
        obs_t o;
        o.a = 4'(ea); o.b = 4'(eb); o.cin = 1'(ec); o.valid = 1'(ev);
        o.st = 2'(es); o.rej = 1'(er);
        return o;
    endfunction

    function automatic obs_t snap();
        obs_t o;
        o.a = a; o.b = b; o.cin = cin; o.valid = valid; o.st = state; o.rej = reject;
        return o;
    endfunction

    task automatic chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: any change of the operand/state outputs, or a reject pulse,
    // is a DUT response and is matched against the next expected entry.
    initial begin : monitor
        obs_t prev, cur, e;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = snap();
            if (reset) begin
                prev = cur;
            end else if (cur.rej || (cur[12:1] != prev[12:1])) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got a=%0d b=%0d cin=%0d valid=%0d state=%0d reject=%0d, expected none",
                             cur.a, cur.b, cur.cin, cur.valid, cur.st, cur.rej);
                end else begin
                    e = exp_q.pop_front();
                    if (cur != e) begin
                        errors++;
                        $display("FAIL event: got a=%0d b=%0d cin=%0d valid=%0d state=%0d reject=%0d, expected a=%0d b=%0d cin=%0d valid=%0d state=%0d reject=%0d",
                                 cur.a, cur.b, cur.cin, cur.valid, cur.st, cur.rej,
                                 e.a, e.b, e.cin, e.valid, e.st, e.rej);
                    end
                end
                prev = cur;
            end
        end
    end

    task automatic press(int d, int c);
        din = 4'(d); cin_in = 1'(c);
        key_n = 1'b0;
        repeat (12) @(negedge clk);
        key_n = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_a"}, int'(a), 0);
        chk({tag, "_b"}, int'(b), 0);
        chk({tag, "_cin"}, int'(cin), 0);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_reject"}, int'(reject), 0);
    endtask

    initial begin : stim
        int n;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("reset");

        // Two captures give a full operand set.
        exp_q.push_back(mk(3, 0, 0, 0, 1, 0));
        press(3, 0);
        exp_q.push_back(mk(3, 7, 1, 1, 2, 0));
        press(7, 1);
        chk("ready_valid", int'(valid), 1);

        // Press in S_READY: din not checked, operands held.
        exp_q.push_back(mk(3, 7, 1, 0, 0, 0));
        press(12, 0);

        // Clear alone, then a non-BCD digit is rejected in S_A.
        @(negedge clk); clear = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        @(negedge clk); clear = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1));
        press(12, 0);
        chk("reject_state", int'(state), 0);
        exp_q.push_back(mk(9, 0, 0, 0, 1, 0));
        press(9, 0);

        // Complete the set, then leave S_READY.
        exp_q.push_back(mk(9, 4, 0, 1, 2, 0));
        press(4, 0);
        exp_q.push_back(mk(9, 4, 0, 0, 0, 0));
        press(1, 1);

        // Long hold: one capture, latency 7 cycles from key_n falling.
        din = 4'd6; cin_in = 1'b0;
        exp_q.push_back(mk(6, 4, 0, 0, 1, 0));
        key_n = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (a == 4'd6) break;
        end
        chk("latency", n, 7);
        repeat (50 - n) @(negedge clk);
        key_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("hold_state", int'(state), 1);

        // Glitch shorter than the debounce window.
        key_n = 1'b0;
        repeat (3) @(negedge clk);
        key_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_state", int'(state), 1);
        chk("glitch_reject", int'(reject), 0);

        // Clear coincident with the press event: no capture, no reject.
        din = 4'd8; cin_in = 1'b1;
        key_n = 1'b0;
        repeat (6) @(negedge clk);
        clear = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        clear = 1'b0;
        repeat (5) @(negedge clk);
        key_n = 1'b1;
        repeat (12) @(negedge clk);

        // Reset mid-entry in S_B, then a fresh capture of A.
        exp_q.push_back(mk(2, 0, 0, 0, 1, 0));
        press(2, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("midreset");
        exp_q.push_back(mk(5, 0, 0, 0, 1, 0));
        press(5, 0);

        repeat (4) @(negedge clk);
        chk("pending_expected", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
